// File: rtl/direction_input.sv
// Debounces four active-low buttons into one-hot single-cycle direction strobes.
// Define DIR_INPUT_AUTOREPEAT_EN to add hold-to-repeat strobes for the accepted button.
module direction_input #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up_n,
    input  logic       btn_down_n,
    input  logic       btn_left_n,
    input  logic       btn_right_n,
    input  logic       enable,
    output logic       isUp,
    output logic       isDown,
    output logic       isLeft,
    output logic       isRight,
    output logic [3:0] held
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("direction_input: DEBOUNCE_CYCLES must be >= 2 and REPEAT_* >= 1");
    end

    // Bit order everywhere is {up, down, left, right}; 1 means pressed.
    logic [3:0]    raw;
    logic [3:0]    sync1_q, sync2_q;
    logic [3:0]    stable_q, stable_d;
    logic [3:0]    prev_q;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    logic [3:0]    press;
    logic [3:0]    win;
    logic [3:0]    strobe_q, strobe_d;

    assign raw = ~{btn_up_n, btn_down_n, btn_left_n, btn_right_n};

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            stable_d[i] = stable_q[i];
            cnt_d[i]    = cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // A press only counts when nothing was held before it; simultaneous presses
    // resolve by priority and the losers are simply dropped.
    assign press = stable_q & ~prev_q;

    always_comb begin
        win = 4'b0000;
        if (enable && prev_q == 4'b0000) begin
            if (press[3])      win = 4'b1000;
            else if (press[2]) win = 4'b0100;
            else if (press[1]) win = 4'b0010;
            else if (press[0]) win = 4'b0001;
        end
    end

`ifdef DIR_INPUT_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_PERIOD} rpt_state_t;

    rpt_state_t    rpt_state_q;
    logic [3:0]    rpt_btn_q;
    logic [RW-1:0] rpt_cnt_q;
    logic [RW-1:0] rpt_last;
    logic          rpt_live, rpt_fire;

    assign rpt_last = (rpt_state_q == RPT_DELAY) ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);
    assign rpt_live = (rpt_state_q != RPT_IDLE) && enable && (stable_q == rpt_btn_q);
    assign rpt_fire = rpt_live && (rpt_cnt_q == rpt_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_state_q <= RPT_IDLE;
            rpt_btn_q   <= 4'b0000;
            rpt_cnt_q   <= '0;
        end else if (win != 4'b0000) begin
            rpt_state_q <= RPT_DELAY;
            rpt_btn_q   <= win;
            rpt_cnt_q   <= '0;
        end else if (rpt_state_q != RPT_IDLE) begin
            if (!rpt_live) begin
                rpt_state_q <= RPT_IDLE;
                rpt_cnt_q   <= '0;
            end else if (rpt_fire) begin
                rpt_state_q <= RPT_PERIOD;
                rpt_cnt_q   <= '0;
            end else begin
                rpt_cnt_q <= rpt_cnt_q + RW'(1);
            end
        end
    end

    assign strobe_d = win | (rpt_fire ? rpt_btn_q : 4'b0000);
`else
    assign strobe_d = win;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 4'b0000;
            sync2_q  <= 4'b0000;
            stable_q <= 4'b0000;
            prev_q   <= 4'b0000;
            strobe_q <= 4'b0000;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            prev_q   <= stable_q;
            strobe_q <= strobe_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign isUp    = strobe_q[3];
    assign isDown  = strobe_q[2];
    assign isLeft  = strobe_q[1];
    assign isRight = strobe_q[0];
    assign held    = stable_q;

endmodule
